// File: rtl/fetch_pc.sv
// Fetch PC generation for rv5stage: holds the fetch PC, applies branch/trap redirects
// (buffered across stalls) and, with FETCH_BTB_EN defined, predicts taken branches via a direct-mapped BTB.
package fetch_pc_pkg;
    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;
endpackage

module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h80000000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  PipeControl  pipe,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic [31:0] addr,
    output logic [31:0] addr_ff,
    output logic        valid_ff,
    output logic        pred_taken_ff,
    output logic [31:0] pred_target_ff
);

    logic        pend_valid;
    logic        pend_exc;
    logic [31:0] pend_target;

    logic        pred_taken;
    logic [31:0] pred_target;

    logic        redirect;
    logic [31:0] redirect_target;

`ifdef FETCH_BTB_EN
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TW-1:0]          btb_tag    [BTB_ENTRIES];
    logic [29:0]            btb_target [BTB_ENTRIES];

    logic [IW-1:0] look_idx;
    logic [IW-1:0] upd_idx;
    logic          unused_low_bits;

    assign look_idx        = addr[IW+1:2];
    assign upd_idx         = upd_pc[IW+1:2];
    assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = 32'h0;
        if (btb_valid[look_idx] && btb_tag[look_idx] == addr[31:IW+2]) begin
            pred_taken  = 1'b1;
            pred_target = {btb_target[look_idx], 2'b00};
        end
    end

    // Training writes at the edge regardless of stall, so a same-cycle lookup sees old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                btb_valid[upd_idx] <= 1'b1;
            end else if (btb_tag[upd_idx] == upd_pc[31:IW+2]) begin
                btb_valid[upd_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[upd_idx]    <= upd_pc[31:IW+2];
            btb_target[upd_idx] <= upd_target[31:2];
        end
    end
`else
    logic unused_upd;

    assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken, BTB_ENTRIES[0]};
    assign pred_taken  = 1'b0;
    assign pred_target = 32'h0;
`endif

    always_comb begin
        redirect        = 1'b0;
        redirect_target = 32'h0;
        if (exc_valid) begin
            redirect        = 1'b1;
            redirect_target = exc_target;
        end else if (pend_valid) begin
            redirect        = 1'b1;
            redirect_target = pend_target;
        end else if (br_valid) begin
            redirect        = 1'b1;
            redirect_target = br_target;
        end
    end

    // A pending exception may only be displaced by a newer exception, never by a branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr           <= RESET_PC;
            addr_ff        <= 32'h0;
            valid_ff       <= 1'b0;
            pred_taken_ff  <= 1'b0;
            pred_target_ff <= 32'h0;
            pend_valid     <= 1'b0;
            pend_exc       <= 1'b0;
            pend_target    <= 32'h0;
        end else if (pipe.stall) begin
            if (exc_valid) begin
                pend_valid  <= 1'b1;
                pend_exc    <= 1'b1;
                pend_target <= exc_target;
            end else if (br_valid && (!pend_valid || !pend_exc)) begin
                pend_valid  <= 1'b1;
                pend_exc    <= 1'b0;
                pend_target <= br_target;
            end
        end else if (redirect) begin
            addr           <= redirect_target;
            addr_ff        <= addr;
            valid_ff       <= 1'b0;
            pred_taken_ff  <= 1'b0;
            pred_target_ff <= 32'h0;
            pend_valid     <= 1'b0;
            pend_exc       <= 1'b0;
            pend_target    <= 32'h0;
        end else begin
            addr_ff        <= addr;
            valid_ff       <= !pipe.flush;
            pred_taken_ff  <= pred_taken && !pipe.flush;
            pred_target_ff <= pipe.flush ? 32'h0 : pred_target;
            addr           <= pred_taken ? pred_target : addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed self-checking bench for fetch_pc; the BTB scenario runs only when FETCH_BTB_EN is defined.
module tb_fetch_pc;
    import fetch_pc_pkg::*;

    logic        clk;
    logic        rst;
    PipeControl  pipe;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] addr;
    logic [31:0] addr_ff;
    logic        valid_ff;
    logic        pred_taken_ff;
    logic [31:0] pred_target_ff;

    int checks = 0;
    int errors = 0;

    fetch_pc dut (
        .clk(clk),
        .rst(rst),
        .pipe(pipe),
        .br_valid(br_valid),
        .br_target(br_target),
        .exc_valid(exc_valid),
        .exc_target(exc_target),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_target(upd_target),
        .upd_taken(upd_taken),
        .addr(addr),
        .addr_ff(addr_ff),
        .valid_ff(valid_ff),
        .pred_taken_ff(pred_taken_ff),
        .pred_target_ff(pred_target_ff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (addr !== 32'h80000000) begin
            errors++;
            $display("[TB] FAIL reset_addr got %h want %h", addr, 32'h80000000);
        end
        checks++;
        if (valid_ff !== 1'b0 || addr_ff !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_ff got valid=%b addr_ff=%h want valid=0 addr_ff=0", valid_ff, addr_ff);
        end
        checks++;
        if (pred_taken_ff !== 1'b0 || pred_target_ff !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_pred got %b/%h want 0/0", pred_taken_ff, pred_target_ff);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (addr !== 32'h80000004 || addr_ff !== 32'h80000000 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_fetch got addr=%h addr_ff=%h valid=%b want 80000004/80000000/1", addr, addr_ff, valid_ff);
        end
        tick();
        tick();
        checks++;
        if (addr !== 32'h8000000C || addr_ff !== 32'h80000008 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL seq_fetch got addr=%h addr_ff=%h valid=%b want 8000000c/80000008/1", addr, addr_ff, valid_ff);
        end
    endtask

    task automatic test_stall_branch();
        pipe.stall = 1'b1;
        tick();
        br_valid  = 1'b1;
        br_target = 32'h80000100;
        tick();
        br_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (addr !== 32'h8000000C || addr_ff !== 32'h80000008 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_hold got addr=%h addr_ff=%h valid=%b want 8000000c/80000008/1", addr, addr_ff, valid_ff);
        end
        pipe.stall = 1'b0;
        tick();
        checks++;
        if (addr !== 32'h80000100 || valid_ff !== 1'b0 || addr_ff !== 32'h8000000C) begin
            errors++;
            $display("[TB] FAIL stall_release got addr=%h addr_ff=%h valid=%b want 80000100/8000000c/0", addr, addr_ff, valid_ff);
        end
        tick();
        checks++;
        if (addr !== 32'h80000104 || addr_ff !== 32'h80000100 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_redirect got addr=%h addr_ff=%h valid=%b want 80000104/80000100/1", addr, addr_ff, valid_ff);
        end
    endtask

    task automatic test_pend_priority();
        pipe.stall = 1'b1;
        br_valid   = 1'b1;
        br_target  = 32'h80000200;
        tick();
        br_valid   = 1'b0;
        exc_valid  = 1'b1;
        exc_target = 32'h80000004;
        tick();
        exc_valid = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h80000300;
        tick();
        br_valid   = 1'b0;
        pipe.stall = 1'b0;
        tick();
        checks++;
        if (addr !== 32'h80000004 || valid_ff !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pend_exc_kept got addr=%h valid=%b want 80000004/0", addr, valid_ff);
        end
        tick();
        checks++;
        if (addr !== 32'h80000008 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pend_cleared got addr=%h valid=%b want 80000008/1", addr, valid_ff);
        end
        // Exception and branch arriving together while stalled.
        pipe.stall = 1'b1;
        exc_valid  = 1'b1;
        exc_target = 32'h80000500;
        br_valid   = 1'b1;
        br_target  = 32'h80000600;
        tick();
        exc_valid  = 1'b0;
        br_valid   = 1'b0;
        pipe.stall = 1'b0;
        tick();
        checks++;
        if (addr !== 32'h80000500) begin
            errors++;
            $display("[TB] FAIL stall_simul got %h want %h", addr, 32'h80000500);
        end
    endtask

    task automatic test_simul_redirect();
        exc_valid  = 1'b1;
        exc_target = 32'h80000040;
        br_valid   = 1'b1;
        br_target  = 32'h80000080;
        tick();
        exc_valid = 1'b0;
        br_valid  = 1'b0;
        checks++;
        if (addr !== 32'h80000040 || valid_ff !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_redirect got addr=%h valid=%b want 80000040/0", addr, valid_ff);
        end
    endtask

    task automatic test_flush();
        pipe.flush = 1'b1;
        tick();
        pipe.flush = 1'b0;
        checks++;
        if (addr !== 32'h80000044 || addr_ff !== 32'h80000040 || valid_ff !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_bubble got addr=%h addr_ff=%h valid=%b want 80000044/80000040/0", addr, addr_ff, valid_ff);
        end
        tick();
        checks++;
        if (addr !== 32'h80000048 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_resume got addr=%h valid=%b want 80000048/1", addr, valid_ff);
        end
    endtask

    task automatic test_wrap();
        br_valid  = 1'b1;
        br_target = 32'hFFFFFFF8;
        tick();
        br_valid = 1'b0;
        tick();
        checks++;
        if (addr !== 32'hFFFFFFFC) begin
            errors++;
            $display("[TB] FAIL wrap_step1 got %h want %h", addr, 32'hFFFFFFFC);
        end
        tick();
        checks++;
        if (addr !== 32'h00000000 || addr_ff !== 32'hFFFFFFFC || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_step2 got addr=%h addr_ff=%h valid=%b want 00000000/fffffffc/1", addr, addr_ff, valid_ff);
        end
    endtask

    task automatic test_reset_pend();
        pipe.stall = 1'b1;
        br_valid   = 1'b1;
        br_target  = 32'h80000700;
        tick();
        br_valid = 1'b0;
        rst      = 1'b1;
        tick();
        checks++;
        if (addr !== 32'h80000000 || valid_ff !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall got addr=%h valid=%b want 80000000/0", addr, valid_ff);
        end
        rst        = 1'b0;
        pipe.stall = 1'b0;
        tick();
        checks++;
        if (addr !== 32'h80000004 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_drops_pend got addr=%h valid=%b want 80000004/1", addr, valid_ff);
        end
    endtask

`ifdef FETCH_BTB_EN
    task automatic test_btb();
        upd_valid  = 1'b1;
        upd_pc     = 32'h80000010;
        upd_target = 32'h80000080;
        upd_taken  = 1'b1;
        tick();
        upd_valid = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h80000010;
        tick();
        br_valid = 1'b0;
        tick();
        checks++;
        if (addr !== 32'h80000080 || addr_ff !== 32'h80000010) begin
            errors++;
            $display("[TB] FAIL btb_hit_addr got addr=%h addr_ff=%h want 80000080/80000010", addr, addr_ff);
        end
        checks++;
        if (pred_taken_ff !== 1'b1 || pred_target_ff !== 32'h80000080 || valid_ff !== 1'b1) begin
            errors++;
            $display("[TB] FAIL btb_hit_pred got %b/%h valid=%b want 1/80000080/1", pred_taken_ff, pred_target_ff, valid_ff);
        end
        upd_valid = 1'b1;
        upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h80000010;
        tick();
        br_valid = 1'b0;
        tick();
        checks++;
        if (addr !== 32'h80000014 || pred_taken_ff !== 1'b0 || pred_target_ff !== 32'h0) begin
            errors++;
            $display("[TB] FAIL btb_cleared got addr=%h pred=%b/%h want 80000014/0/0", addr, pred_taken_ff, pred_target_ff);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        pipe       = '0;
        br_valid   = 1'b0;
        br_target  = 32'h0;
        exc_valid  = 1'b0;
        exc_target = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_target = 32'h0;
        upd_taken  = 1'b0;
        test_reset();
        test_stall_branch();
        test_pend_priority();
        test_simul_redirect();
        test_flush();
        test_wrap();
        test_reset_pend();
`ifdef FETCH_BTB_EN
        test_btb();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Program-counter generation stage of the rv5stage pipeline, directly upstream of the instruction-cache fetch stage. Holds the architectural fetch PC and drives `addr` (the address requested this cycle) and `addr_ff` (the address whose word returns on `inst`). Applies branch and trap redirects and buffers a redirect that arrives while the front end is stalled. An optional direct-mapped BTB predicts taken branches.

## Interface
Parameters:
- `RESET_PC`, default `32'h80000000`: fetch address after reset.
- `BTB_ENTRIES`, default 16: number of BTB entries; power of 2, at least 2. Index width is `IW = log2(BTB_ENTRIES)`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `pipe`  in  PipeControl  uses `stall` and `flush` from the hazard unit.
- `br_valid`  in  1  branch or jump redirect from execute.
- `br_target`  in  32  redirect address.
- `exc_valid`  in  1  trap or `mret` redirect from commit.
- `exc_target`  in  32  trap vector or return address.
- `upd_valid`  in  1  BTB training strobe from execute.
- `upd_pc`  in  32  address of the resolved branch.
- `upd_target`  in  32  resolved target.
- `upd_taken`  in  1  branch was taken.
- `addr`  out  32  fetch address presented to the icache this cycle.
- `addr_ff`  out  32  address of the fetch in flight; aligned with `inst`.
- `valid_ff`  out  1  `addr_ff` is a real, non-squashed fetch.
- `pred_taken_ff`  out  1  BTB predicted taken for `addr_ff`.
- `pred_target_ff`  out  32  predicted target for `addr_ff`; 0 when not predicted.

## Operation
- State:
  - PC register (drives `addr`).
  - Output registers: `addr_ff`, `valid_ff`, `pred_taken_ff`, `pred_target_ff`.
  - Pending redirect: `pend_valid`, `pend_exc`, `pend_target`.
  - BTB array, when the BTB is compiled in.
- Reset values: `addr` = `RESET_PC`; `addr_ff` = 0; `valid_ff` = 0; `pred_taken_ff` = 0; `pred_target_ff` = 0; pend* = 0; all BTB valid bits = 0.
- Redirect source selection, in priority order:
  1. `exc_valid` with `exc_target`.
  2. Pending redirect.
  3. `br_valid` with `br_target`.
- Cycle with `pipe.stall` = 1:
  - PC and all *_ff outputs hold.
  - A new `exc_valid` loads pend with `pend_exc` = 1. This overwrites any pending branch.
  - A new `br_valid` loads pend only if `pend_valid` = 0 or `pend_exc` = 0.
  - When `exc_valid` and `br_valid` arrive together, the exception is kept.
- Cycle with `pipe.stall` = 0 and a redirect selected:
  - `addr` <= target.
  - `valid_ff` <= 0, `pred_taken_ff` <= 0, `pred_target_ff` <= 0.
  - `addr_ff` <= `addr`.
  - pend cleared.
- Cycle with `pipe.stall` = 0, no redirect, and `pipe.flush` = 1:
  - `addr` advances as in a normal cycle.
  - `valid_ff` <= 0 (bubble).
- Normal cycle:
  - `addr_ff` <= `addr`; `valid_ff` <= 1; `pred_*_ff` <= current prediction.
  - `addr` <= predicted target if the prediction is taken, otherwise `addr + 4`.
- Arithmetic: `addr + 4` is modulo 2^32, so `32'hFFFFFFFC` -> `32'h00000000`. No alignment or range checks are done here; the icache flags errors.
- `rst` asserted mid-stall or with pend set: reset values win; the pending redirect is lost.

## Timing
- Redirect to `addr`: 1 cycle when unstalled. When stalled, it takes effect in the first cycle after `stall` falls.
- `addr_ff` equals the previous unstalled cycle's `addr`, so `inst` from the icache pairs with it.
- BTB lookup: combinational on `addr`, same cycle.
- BTB update:
  - Writes at the clock edge, including during stall.
  - A lookup of the same index in the same cycle sees the old contents.

## Configuration
- Macro `FETCH_BTB_EN`.
- Defined:
  - `BTB_ENTRIES`-entry direct-mapped BTB.
  - Index is `addr[IW+1:2]`; tag is `addr[31:IW+2]`; each entry stores `target[31:2]`.
  - Hit = valid and tag match; a hit predicts taken.
  - Training: `upd_valid` with `upd_taken` = 1 writes the entry (valid = 1, tag, target). `upd_valid` with `upd_taken` = 0 clears the valid bit only on a tag match.
- Undefined:
  - No BTB storage.
  - Prediction is always not-taken; `pred_taken_ff` and `pred_target_ff` stay 0.
  - `upd_*` inputs are ignored.

## Test plan
- Reset, then 3 unstalled cycles -> `addr` = `0x8000000C`, `addr_ff` = `0x80000008`, `valid_ff` = 1; during reset `addr` = `0x80000000` and `valid_ff` = 0.
- `stall` for 4 cycles with `br_valid` (target `0x80000100`) in stall cycle 2 -> `addr` holds; one cycle after `stall` falls `addr` = `0x80000100` and `valid_ff` = 0.
- During stall, `br_valid` (`0x80000200`) then `exc_valid` (`0x80000004`), then `br_valid` again -> after release `addr` = `0x80000004`.
- Unstalled `exc_valid` (`0x80000040`) and `br_valid` (`0x80000080`) in the same cycle -> `addr` = `0x80000040`.
- Redirect to `0xFFFFFFF8`, run 2 cycles -> `addr` goes `0xFFFFFFFC` then `0x00000000`.
- With `FETCH_BTB_EN`: `upd` taken for pc `0x80000010` -> `0x80000080`; refetch `0x80000010` -> next `addr` = `0x80000080`, `pred_taken_ff` = 1. Then `upd` not-taken for the same pc -> the next fetch of `0x80000010` yields `0x80000014`.
